// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder: memory op codes, FSM states
// and the alignment rule used when a request is accepted.
package dmem_resp_pkg;

    typedef enum logic [3:0] {
        MEM_OP_NOP = 4'd0,
        MEM_OP_LB  = 4'd1,
        MEM_OP_LH  = 4'd2,
        MEM_OP_LW  = 4'd3,
        MEM_OP_LBU = 4'd4,
        MEM_OP_LHU = 4'd5,
        MEM_OP_SB  = 4'd6,
        MEM_OP_SH  = 4'd7,
        MEM_OP_SW  = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LD_RSP = 2'd1,
        RMW_WR = 2'd2
    } state_e;

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (op)
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: mis = off[0];
            MEM_OP_LW, MEM_OP_SW:             mis = |off;
            default:                          mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/dmem_resp_lane_mux.sv
// Byte/half lane steering: extracts and extends load data, and merges sub-word
// store data into the word read back from SRAM.
module dmem_resp_lane_mux
    import dmem_resp_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [3:0]            op,
    input  logic [1:0]            off,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [15:0]           wdata,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic [DATA_WIDTH-1:0] store_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{off, 3'b000} +: 8];
    assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = '0;
        case (op)
            MEM_OP_LB:  load_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            MEM_OP_LBU: load_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            MEM_OP_LH:  load_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            MEM_OP_LHU: load_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            MEM_OP_LW:  load_data = rdata;
            default:    load_data = '0;
        endcase
    end

    always_comb begin
        store_data = rdata;
        case (op)
            MEM_OP_SB: store_data[{off, 3'b000} +: 8] = wdata[7:0];
            MEM_OP_SH: begin
                if (off[1]) store_data[31:16] = wdata;
                else        store_data[15:0]  = wdata;
            end
            default:   store_data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: serves MEM-stage loads/stores against a word-wide
// synchronous SRAM, using read-modify-write for SB/SH and one stall cycle per multi-cycle access.
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WORD_AW    = 19
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_ce_i,
    input  logic [3:0]            req_op_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_valid_o,
    output logic                  err_o,
    output logic                  stallreq_o,
    output logic                  sram_ce_o,
    output logic                  sram_we_o,
    output logic [WORD_AW-1:0]    sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

    state_e               state_q, state_d;
    logic [3:0]           op_p1;
    logic [1:0]           off_p1;
    logic [15:0]          wdata_p1;
    logic [WORD_AW-1:0]   waddr_p1;
    logic [WORD_AW-1:0]   req_word;
    logic                 req_mis;
    logic [DATA_WIDTH-1:0] load_data, store_data;
    logic                 unused_addr_bits;

    assign req_word         = req_addr_i[WORD_AW+1:2];
    assign req_mis          = is_misaligned(req_op_i, req_addr_i[1:0]);
    assign unused_addr_bits = ^req_addr_i[ADDR_WIDTH-1:WORD_AW+2];

    // Stage p0 -> p1: request captured while idle, consumed in LD_RSP/RMW_WR
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            op_p1    <= '0;
            off_p1   <= '0;
            wdata_p1 <= '0;
            waddr_p1 <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                op_p1    <= req_op_i;
                off_p1   <= req_addr_i[1:0];
                wdata_p1 <= req_wdata_i[15:0];
                waddr_p1 <= req_word;
            end
        end
    end

    dmem_resp_lane_mux #(.DATA_WIDTH(DATA_WIDTH)) u_lane_mux (
        .op         (op_p1),
        .off        (off_p1),
        .rdata      (sram_rdata_i),
        .wdata      (wdata_p1),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_comb begin
        state_d      = state_q;
        rsp_rdata_o  = '0;
        rsp_valid_o  = 1'b0;
        err_o        = 1'b0;
        stallreq_o   = 1'b0;
        sram_ce_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        // Reset forces every output low, so an in-flight RMW write is dropped.
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (req_ce_i) begin
                        case (req_op_i)
                            MEM_OP_LB, MEM_OP_LBU, MEM_OP_LH, MEM_OP_LHU, MEM_OP_LW: begin
                                if (req_mis) begin
                                    err_o = 1'b1;
                                end else begin
                                    sram_ce_o   = 1'b1;
                                    sram_addr_o = req_word;
                                    stallreq_o  = 1'b1;
                                    state_d     = LD_RSP;
                                end
                            end
                            MEM_OP_SB, MEM_OP_SH: begin
                                if (req_mis) begin
                                    err_o = 1'b1;
                                end else begin
                                    sram_ce_o   = 1'b1;
                                    sram_addr_o = req_word;
                                    stallreq_o  = 1'b1;
                                    state_d     = RMW_WR;
                                end
                            end
                            MEM_OP_SW: begin
                                if (req_mis) begin
                                    err_o = 1'b1;
                                end else begin
                                    sram_ce_o    = 1'b1;
                                    sram_we_o    = 1'b1;
                                    sram_addr_o  = req_word;
                                    sram_wdata_o = req_wdata_i;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                LD_RSP: begin
                    rsp_valid_o = 1'b1;
                    rsp_rdata_o = load_data;
                    state_d     = IDLE;
                end
                RMW_WR: begin
                    sram_ce_o    = 1'b1;
                    sram_we_o    = 1'b1;
                    sram_addr_o  = waddr_p1;
                    sram_wdata_o = store_data;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: per-transaction reference model of memory and
// response timing, a per-cycle compare process, and literal pins on key results.
module tb_dmem_resp;
    import dmem_resp_pkg::*;

    typedef struct packed {
        logic        ce;
        logic        we;
        logic [18:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic        err;
        logic        valid;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] req;
    } pin_t;

    logic        clk;
    logic        rst_i;
    logic        req_ce_i;
    logic [3:0]  req_op_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_valid_o;
    logic        err_o;
    logic        stallreq_o;
    logic        sram_ce_o;
    logic        sram_we_o;
    logic [18:0] sram_addr_o;
    logic [31:0] sram_wdata_o;
    logic [31:0] sram_rdata_i = '0;

    logic [31:0] mem     [0:255] = '{default: 32'h0};
    logic [31:0] ref_mem [0:255] = '{default: 32'h0};

    exp_t        exp_q[$];
    pin_t        pin_q[$];
    exp_t        cur;
    pin_t        pc;
    int          checks = 0;
    int          errors = 0;
    int          stall_run = 0;
    logic [31:0] last_rdata = '0;

    dmem_resp dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_ce_i     (req_ce_i),
        .req_op_i     (req_op_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_valid_o  (rsp_valid_o),
        .err_o        (err_o),
        .stallreq_o   (stallreq_o),
        .sram_ce_o    (sram_ce_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .sram_rdata_i (sram_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port SRAM: read data appears the cycle after a read.
    always @(posedge clk) begin
        if (sram_ce_o) begin
            if (sram_we_o) mem[sram_addr_o[7:0]] <= sram_wdata_o;
            else           sram_rdata_i <= mem[sram_addr_o[7:0]];
        end
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            checks++;
            if (sram_ce_o !== cur.ce || sram_we_o !== cur.we || stallreq_o !== cur.stall ||
                err_o !== cur.err || rsp_valid_o !== cur.valid || rsp_rdata_o !== cur.rdata ||
                (cur.ce && sram_addr_o !== cur.addr) || (cur.we && sram_wdata_o !== cur.wdata)) begin
                errors++;
                $display("FAIL cycle t=%0t act ce=%b we=%b a=%h wd=%h st=%b err=%b v=%b rd=%h req ce=%b we=%b a=%h wd=%h st=%b err=%b v=%b rd=%h",
                         $time, sram_ce_o, sram_we_o, sram_addr_o, sram_wdata_o, stallreq_o, err_o,
                         rsp_valid_o, rsp_rdata_o, cur.ce, cur.we, cur.addr, cur.wdata, cur.stall,
                         cur.err, cur.valid, cur.rdata);
            end
            if (rsp_valid_o) last_rdata = rsp_rdata_o;
        end
        stall_run = (stallreq_o === 1'b1) ? stall_run + 1 : 0;
        checks++;
        if (stall_run > 1 || (rsp_valid_o === 1'b1 && err_o === 1'b1)) begin
            errors++;
            $display("FAIL invariant t=%0t stall_run=%0d valid=%b err=%b req stall_run<=1 and not both",
                     $time, stall_run, rsp_valid_o, err_o);
        end
        while (pin_q.size() > 0) begin
            pc = pin_q.pop_front();
            checks++;
            if (pc.act !== pc.req) begin
                errors++;
                $display("FAIL %s act=%h req=%h", pc.name, pc.act, pc.req);
            end
        end
    end

    function automatic logic [31:0] ld_model(input logic [3:0] op, input logic [31:0] w,
                                             input logic [1:0] off);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
        case (op)
            MEM_OP_LB:  return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
            MEM_OP_LBU: return b;
            MEM_OP_LH:  return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
            MEM_OP_LHU: return h;
            MEM_OP_LW:  return w;
            default:    return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] st_model(input logic [3:0] op, input logic [31:0] old,
                                             input logic [31:0] wd, input logic [1:0] off);
        logic [31:0] mask;
        int          sh;
        sh   = (op == MEM_OP_SB) ? 8 * off : (off[1] ? 16 : 0);
        mask = ((op == MEM_OP_SB) ? 32'hFF : 32'hFFFF) << sh;
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    task automatic pin(input string name, input logic [31:0] act, input logic [31:0] req);
        pin_q.push_back('{name, act, req});
    endtask

    task automatic cyc(input logic r, input logic c, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] wd, input exp_t e);
        rst_i       = r;
        req_ce_i    = c;
        req_op_i    = op;
        req_addr_i  = a;
        req_wdata_i = wd;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd);
        exp_t        e1, e2;
        int unsigned size;
        logic [7:0]  w;
        w  = a[9:2];
        e1 = '0;
        e2 = '0;
        case (op)
            MEM_OP_LB, MEM_OP_LBU, MEM_OP_SB: size = 1;
            MEM_OP_LH, MEM_OP_LHU, MEM_OP_SH: size = 2;
            MEM_OP_LW, MEM_OP_SW:             size = 4;
            default:                          size = 0;
        endcase
        if (size == 0) begin
            cyc(1'b0, 1'b1, op, a, wd, e1);
        end else if ((a % size) != 0) begin
            e1.err = 1'b1;
            cyc(1'b0, 1'b1, op, a, wd, e1);
        end else if (op == MEM_OP_SW) begin
            e1.ce = 1'b1; e1.we = 1'b1; e1.addr = a[20:2]; e1.wdata = wd;
            cyc(1'b0, 1'b1, op, a, wd, e1);
            ref_mem[w] = wd;
        end else begin
            e1.ce = 1'b1; e1.addr = a[20:2]; e1.stall = 1'b1;
            if (op == MEM_OP_SB || op == MEM_OP_SH) begin
                e2.ce = 1'b1; e2.we = 1'b1; e2.addr = a[20:2];
                e2.wdata = st_model(op, ref_mem[w], wd, a[1:0]);
            end else begin
                e2.valid = 1'b1;
                e2.rdata = ld_model(op, ref_mem[w], a[1:0]);
            end
            cyc(1'b0, 1'b1, op, a, wd, e1);
            cyc(1'b0, 1'b1, op, a, wd, e2);
            if (e2.we) ref_mem[w] = e2.wdata;
        end
    endtask

    initial begin
        exp_t z;
        exp_t rd;
        z = '0;
        rst_i = 1'b1; req_ce_i = 1'b0; req_op_i = '0; req_addr_i = '0; req_wdata_i = '0;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b1, MEM_OP_LW, 32'h10, 32'h0, z);
        cyc(1'b1, 1'b1, MEM_OP_SW, 32'h10, 32'h55, z);

        xact(MEM_OP_SW, 32'h10, 32'hDEADBEEF);
        pin("sw_mem", mem[4], 32'hDEADBEEF);
        xact(MEM_OP_LW, 32'h10, 32'h0);
        pin("lw", last_rdata, 32'hDEADBEEF);
        xact(MEM_OP_LB, 32'h13, 32'h0);
        pin("lb", last_rdata, 32'hFFFFFFDE);
        xact(MEM_OP_LBU, 32'h13, 32'h0);
        pin("lbu", last_rdata, 32'h000000DE);
        xact(MEM_OP_LH, 32'h12, 32'h0);
        pin("lh", last_rdata, 32'hFFFFDEAD);
        xact(MEM_OP_LHU, 32'h12, 32'h0);
        pin("lhu", last_rdata, 32'h0000DEAD);

        xact(MEM_OP_SB, 32'h11, 32'h000000A5);
        pin("sb_mem", mem[4], 32'hDEADA5EF);
        xact(MEM_OP_SW, 32'h10, 32'hDEADBEEF);
        xact(MEM_OP_SH, 32'h12, 32'h00001234);
        pin("sh_mem", mem[4], 32'h1234BEEF);

        xact(MEM_OP_LH, 32'h11, 32'h0);
        xact(MEM_OP_SW, 32'h12, 32'hCAFEF00D);
        xact(MEM_OP_NOP, 32'h10, 32'h0);
        xact(4'hF, 32'h10, 32'hFFFFFFFF);
        cyc(1'b0, 1'b0, MEM_OP_SW, 32'h10, 32'h0BADF00D, z);
        pin("err_mem", mem[4], 32'h1234BEEF);

        // Reset lands on the RMW write cycle: nothing may be written.
        rd = '0; rd.ce = 1'b1; rd.addr = 19'd4; rd.stall = 1'b1;
        cyc(1'b0, 1'b1, MEM_OP_SB, 32'h10, 32'h77, rd);
        cyc(1'b1, 1'b1, MEM_OP_SB, 32'h10, 32'h77, z);
        cyc(1'b0, 1'b0, MEM_OP_NOP, 32'h0, 32'h0, z);
        pin("rst_mem", mem[4], 32'h1234BEEF);

        xact(MEM_OP_SB, 32'h10, 32'h00000011);
        xact(MEM_OP_LW, 32'h10, 32'h0);
        pin("b2b_lw", last_rdata, 32'h1234BE11);
        xact(MEM_OP_LB, 32'h10, 32'h0);
        pin("lb0", last_rdata, 32'h00000011);
        xact(MEM_OP_LHU, 32'h10, 32'h0);
        pin("lhu0", last_rdata, 32'h0000BE11);

        xact(MEM_OP_SW, 32'h24, 32'h80FF7F01);
        xact(MEM_OP_LB, 32'h27, 32'h0);
        pin("lb3", last_rdata, 32'hFFFFFF80);
        xact(MEM_OP_LB, 32'h25, 32'h0);
        pin("lb1", last_rdata, 32'h0000007F);
        xact(MEM_OP_LH, 32'h26, 32'h0);
        pin("lh_hi", last_rdata, 32'hFFFF80FF);
        xact(MEM_OP_SH, 32'h24, 32'h0000ABCD);
        pin("sh_lo", mem[9], 32'h80FFABCD);
        xact(MEM_OP_LW, 32'h13, 32'h0);
        xact(MEM_OP_SH, 32'h27, 32'h1);
        pin("mis_mem", mem[9], 32'h80FFABCD);

        cyc(1'b0, 1'b0, MEM_OP_NOP, 32'h0, 32'h0, z);
        cyc(1'b0, 1'b0, MEM_OP_NOP, 32'h0, 32'h0, z);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
